// File: rtl/toggle_xfer_tx_pkg.sv
// -----------------------------------------------------------------------------
// toggle_xfer_pkg
// Shared types and defaults for both ends of the toggle-handshake crossing.
//   xfer_state_t : source-side FSM states
//   DEF_DATA_W   : default width of the transferred word
//   cnt_w()      : width of a counter that must hold values 0 .. t-1
// -----------------------------------------------------------------------------
package toggle_xfer_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } xfer_state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 255;

    // Bits needed to count from 0 up to t-1; never narrower than one bit.
    function automatic int cnt_w(input int t);
        if (t < 2) begin
            return 1;
        end else begin
            return $clog2(t);
        end
    endfunction

endpackage

// File: rtl/toggle_xfer_tx_if.sv
// -----------------------------------------------------------------------------
// toggle_xfer_tx_if
// Bundles the sending-side handshake (send_valid/send_data/send_ready), the
// crossing signals (req_tog/xfer_data/ack_tog) and the status/error signals.
//   slave  : view used by toggle_xfer_tx
//   master : view used by whatever drives the transmitter
// -----------------------------------------------------------------------------
interface toggle_xfer_tx_if
    import toggle_xfer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              send_valid;
    logic [DATA_W-1:0] send_data;
    logic              send_ready;
    logic              req_tog;
    logic [DATA_W-1:0] xfer_data;
    logic              ack_tog;
    logic              done_pulse;
    logic              timeout_err;
    logic              err_clr;

    modport slave (
        input  send_valid, send_data, ack_tog, err_clr,
        output send_ready, req_tog, xfer_data, done_pulse, timeout_err
    );

    modport master (
        output send_valid, send_data, ack_tog, err_clr,
        input  send_ready, req_tog, xfer_data, done_pulse, timeout_err
    );

endinterface

// File: rtl/toggle_xfer_tx_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level.
//   clk : destination clock
//   rst : synchronous, active-high reset (both stages to 0)
//   d   : asynchronous input level
//   q   : synchronized level, two edges behind d
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic s1;
    (* ASYNC_REG = "TRUE" *) logic s2;

    // Synchronizer stages; s1 may go metastable, s2 gives it a cycle to settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/toggle_xfer_tx.sv
// -----------------------------------------------------------------------------
// toggle_xfer_tx
// Source side of a toggle-handshake clock-domain crossing. A word accepted in
// IDLE is captured into xfer_data and announced by flipping req_tog; the word
// is held until the synchronized ack_tog level matches req_tog again.
//   clk_a, rst_a : sending-domain clock, synchronous active-high reset
//   bus (slave)  : send_valid/send_data/send_ready, req_tog/xfer_data/ack_tog,
//                  done_pulse, timeout_err, err_clr
// Parameters: DATA_W word width; TIMEOUT_CYC ack wait limit (0 = no limit).
// -----------------------------------------------------------------------------
module toggle_xfer_tx
    import toggle_xfer_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic            clk_a,
    input  logic            rst_a,
    toggle_xfer_tx_if.slave bus
);

    localparam int                CNT_W    = cnt_w(TIMEOUT_CYC);
    localparam bit                TMO_EN   = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

    xfer_state_t       state;
    xfer_state_t       state_nxt;
    logic              req_tog;
    logic [DATA_W-1:0] xfer_data;
    logic              send_ready;
    logic              done_pulse;
    logic              timeout_err;
    logic [CNT_W-1:0]  cnt;
    logic              ack_s2;
    logic              accept;
    logic              ack_seen;
    logic              expire;

    sync_2ff u_ack_sync (
        .clk (clk_a),
        .rst (rst_a),
        .d   (bus.ack_tog),
        .q   (ack_s2)
    );

    // Next-state and event decode. The ack test is a level compare, so an ack
    // arriving after a timeout simply leaves the levels equal and is absorbed.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_seen  = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.send_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT_ACK;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_ACK: begin
                if (ack_s2 == req_tog) begin
                    ack_seen  = 1'b1;
                    state_nxt = IDLE;
                end else if (TMO_EN && (cnt == TMO_LAST)) begin
                    expire    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_ACK;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus all registered outputs and the wait counter.
    always_ff @(posedge clk_a) begin
        if (rst_a) begin
            state       <= IDLE;
            req_tog     <= 1'b0;
            xfer_data   <= {DATA_W{1'b0}};
            send_ready  <= 1'b1;
            done_pulse  <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= {CNT_W{1'b0}};
        end else begin
            state      <= state_nxt;
            send_ready <= (state_nxt == IDLE);
            done_pulse <= ack_seen;
            if (accept) begin
                xfer_data <= bus.send_data;
                req_tog   <= ~req_tog;
                cnt       <= {CNT_W{1'b0}};
            end else if ((state == WAIT_ACK) && !ack_seen) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= cnt;
            end
            // A timeout in the same cycle as err_clr keeps the flag set.
            if (expire) begin
                timeout_err <= 1'b1;
            end else if (bus.err_clr) begin
                timeout_err <= 1'b0;
            end else begin
                timeout_err <= timeout_err;
            end
        end
    end

    assign bus.send_ready  = send_ready;
    assign bus.req_tog     = req_tog;
    assign bus.xfer_data   = xfer_data;
    assign bus.done_pulse  = done_pulse;
    assign bus.timeout_err = timeout_err;

endmodule
